// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: accepts one instruction per handshake and walks
// EXEC -> MEM -> WB with registered control outputs, memory timeout and stall freeze.
module multicycle_control #(
  parameter int OP_W        = 3,
  parameter int FUNC_W      = 4,
  parameter int ALUOP_W     = 3,
  parameter int RS_W        = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNC_W-1:0]  func,
  output logic               instr_ready,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               RegWrite,
  output logic               ALUsrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [RS_W-1:0]    RegStore,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               Branch,
  output logic               JumpOut,
  output logic               illegal,
  output logic               mem_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MEM = 2'd2, WB = 2'd3} state_t;

  typedef struct packed {
    logic               regwrite;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic [RS_W-1:0]    regstore;
    logic               memwrite;
    logic               memread;
    logic               branch;
    logic               jumpout;
  } ctrl_t;

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t          state_r;
  logic [OP_W-1:0] op_r;
  logic [CNT_W-1:0] cnt_r;
  ctrl_t           ctrl_r;
  logic            illegal_r;
  logic            mem_err_r;

  function automatic logic is_illegal(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
    return ((op & ~OP_W'(7)) != '0) || ((op == OP_W'(0)) && (fn > FUNC_W'(3)));
  endfunction

  // EXEC-state controls, loaded at the accept edge from the instruction being latched
  function automatic ctrl_t exec_decode(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_W'(0): begin
        c.alusrc   = 1'b1;
        c.regstore = RS_W'(1);
        c.aluop    = ALUOP_W'(fn[1:0]) + ALUOP_W'(1);
      end
      OP_W'(1): begin
        c.regstore = RS_W'(1);
        case (fn[3:2])
          2'd0:    c.aluop = ALUOP_W'(1);
          2'd1:    c.aluop = ALUOP_W'(5);
          2'd2:    c.aluop = ALUOP_W'(6);
          default: c.aluop = ALUOP_W'(7);
        endcase
      end
      OP_W'(2), OP_W'(3): c.aluop = ALUOP_W'(1);
      OP_W'(4), OP_W'(5): begin
        c.branch = 1'b1;
        c.aluop  = ALUOP_W'(2);
      end
      OP_W'(6): begin
        c.branch   = 1'b1;
        c.regstore = RS_W'(2);
      end
      OP_W'(7): begin
        c.branch  = 1'b1;
        c.jumpout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t mem_ctrl(input logic is_store);
    ctrl_t c;
    c = '0;
    c.aluop    = ALUOP_W'(1);
    c.memwrite = is_store;
    c.memread  = ~is_store;
    return c;
  endfunction

  function automatic ctrl_t wb_ctrl(input logic [RS_W-1:0] rs);
    ctrl_t c;
    c = '0;
    c.regwrite = 1'b1;
    c.regstore = rs;
    return c;
  endfunction

  // Sequencer state, latched opcode, MEM counter and registered outputs; stall freezes all
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      op_r      <= '0;
      cnt_r     <= '0;
      ctrl_r    <= '0;
      illegal_r <= 1'b0;
      mem_err_r <= 1'b0;
    end else if (!stall) begin
      illegal_r <= 1'b0;
      mem_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          ctrl_r <= '0;
          if (instr_valid) begin
            if (is_illegal(opcode, func)) begin
              illegal_r <= 1'b1;
            end else begin
              op_r    <= opcode;
              ctrl_r  <= exec_decode(opcode, func);
              state_r <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt_r <= '0;
          if (op_r == OP_W'(0) || op_r == OP_W'(1)) begin
            ctrl_r  <= wb_ctrl(ctrl_r.regstore);
            state_r <= WB;
          end else if (op_r == OP_W'(2) || op_r == OP_W'(3)) begin
            ctrl_r  <= mem_ctrl(op_r == OP_W'(3));
            state_r <= MEM;
          end else begin
            ctrl_r  <= '0;
            state_r <= IDLE;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (op_r == OP_W'(2)) begin
              ctrl_r  <= wb_ctrl(ctrl_r.regstore);
              state_r <= WB;
            end else begin
              ctrl_r  <= '0;
              state_r <= IDLE;
            end
          end else if ((MEM_TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            mem_err_r <= 1'b1;
            ctrl_r    <= '0;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WB: begin
          ctrl_r  <= '0;
          state_r <= IDLE;
        end
        default: begin
          ctrl_r  <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held
  assign instr_ready = reset && (state_r == IDLE) && !stall;
  assign RegWrite    = ctrl_r.regwrite;
  assign ALUsrc      = ctrl_r.alusrc;
  assign ALUop       = ctrl_r.aluop;
  assign RegStore    = ctrl_r.regstore;
  assign MemWrite    = ctrl_r.memwrite;
  assign MemRead     = ctrl_r.memread;
  assign Branch      = ctrl_r.branch;
  assign JumpOut     = ctrl_r.jumpout;
  assign illegal     = illegal_r;
  assign mem_err     = mem_err_r;

endmodule
